uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART path: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous `rx` line and presents each byte as a one-cycle `valid` pulse. It sits directly downstream of the UART transmitter and must interoperate with it at the same `CLK_PER_BIT` setting. It provides framing-error reporting and false-start rejection.

## Interface
- `CLK_PER_BIT`, default 16: clock cycles per bit. Must be even and ≥ 4.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `data_out`  out  8  last correctly framed byte; holds its value until the next good frame.
- `valid`  out  1  one-cycle pulse; `data_out` is new in the same cycle.
- `frame_err`  out  1  one-cycle pulse; the stop bit was sampled low.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Synchronizer: 2 flops, both preset to 1 on reset. The synchronized value is `rx_s`.
- Registers:
  - Bit counter `cnt`, width `$clog2(CLK_PER_BIT)`.
  - Bit index, 3 bits.
  - Shifter, 8 bits.
  - Sample history: the last 3 values of `rx_s`.
- Reset values:
  - `data_out`=0x00, `valid`=0, `frame_err`=0, `busy`=0.
  - State IDLE, `cnt`=0.
- States:
  - IDLE: on `rx_s`==0, go to START with `cnt`=0.
  - START: increment `cnt`. When `cnt`==`CLK_PER_BIT`/2−1, evaluate the bit.
    - Bit low: go to DATA with `cnt`=0 and index=0.
    - Bit high: false start; go to IDLE with no pulse.
  - DATA: increment `cnt`. When `cnt`==`CLK_PER_BIT`−1:
    - Set `cnt`=0 and write the bit into `shifter[index]`.
    - Index 7 goes to STOP; otherwise increment the index.
  - STOP: when `cnt`==`CLK_PER_BIT`−1, evaluate the bit.
    - Bit high: load `data_out` from the shifter, pulse `valid`, go to IDLE.
    - Bit low: pulse `frame_err`, go to BREAK. `data_out` is unchanged.
  - BREAK: wait for `rx_s`==1, then go to IDLE. No pulses are generated here.
- Bit evaluation uses `rx_s` at the sample edge, or the majority vote when the configuration macro is defined (see Configuration).
- `valid` and `frame_err` are never high in the same cycle. Each asserts for exactly 1 cycle per frame.
- A new start bit is accepted on the first cycle IDLE sees `rx_s`==0. Back-to-back frames need no idle gap beyond the stop bit.
- Reset mid-frame: the partial byte is discarded and no pulse is generated.
  - If `rx` is low when reset releases, a start is detected after the synchronizer latency.
  - The resulting `frame_err` or false start is accepted behaviour.

## Timing
- Edge numbering: E0 is the first `clk` edge that registers `rx` low into the synchronizer.
  - `rx_s` is low after E1.
  - IDLE detects the start at E2.
- Start-bit evaluation is at E(2+C/2), where C=`CLK_PER_BIT`.
- Data bit i (i=0..7) is evaluated at E(2+C/2+C·(i+1)).
- The stop bit is evaluated at E(2+C/2+9C).
  - `valid` or `frame_err` is high in the following cycle.
  - For C=16, that is the cycle after E154.
- `busy` rises after E2 and falls together with the `valid` or `frame_err` pulse.
  - Exception: after a framing error, `busy` stays high through BREAK.
- The evaluation point (`cnt` match) is the same with or without the majority option.

## Configuration
- Macro: `UART_RX_MAJORITY_EN`.
- Defined: each bit value is the 2-of-3 majority of `rx_s` at the evaluation edge and the two preceding edges. This rejects any single-cycle glitch at mid-bit.
- Undefined: each bit value is `rx_s` at the evaluation edge only, and the sample history is not instantiated.
- Ports and latency are identical in both builds.

## Test plan
- Single frame: byte 0xA5 at C=16 from idle.
  - `valid` pulses in the cycle after E154.
  - `data_out`=0xA5, `frame_err`=0, `busy`=0 afterwards.
- Back-to-back: 0x00 then 0xFF with no idle gap.
  - Two `valid` pulses 160 cycles apart, carrying 0x00 and 0xFF.
- False start: `rx` low for 3 cycles, then high.
  - No `valid` and no `frame_err`.
  - `busy` returns to 0 after E(2+C/2), i.e. the cycle after E10 at C=16.
- Framing error: send 0x3C with the stop bit driven low, hold `rx` low 40 cycles, then release.
  - `frame_err` pulses once.
  - `data_out` keeps its previous value.
  - `busy` stays high until `rx_s` returns high.
  - A following 0x55 frame is received correctly.
- Glitch: a 1-cycle inversion placed on the evaluation edge of data bit 3 of 0x00.
  - With `UART_RX_MAJORITY_EN`: `data_out`=0x00.
  - Without: `data_out`=0x08.
- Reset mid-frame: assert `rst_n` low during data bit 4 of 0x81.
  - All outputs return to their reset values and no `valid` is generated.
  - After release, a clean 0x81 frame is received.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with false-start rejection and framing-error reporting.
// Define UART_RX_MAJORITY_EN to evaluate each bit as a 2-of-3 vote over the last three rx_s samples.
module uart_rx #(
  parameter int CLK_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLK_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    index, index_next;
  logic [7:0]    shifter, shifter_next;
  logic [7:0]    data_next;
  logic          valid_next, frame_err_next;
  logic          rx_meta, rx_s;
  logic          bit_val;

  // Both synchronizer flops preset high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= 2'b11;
    end else begin
      hist <= {hist[0], rx_s};
    end
  end

  assign bit_val = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      index     <= '0;
      shifter   <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      index     <= index_next;
      shifter   <= shifter_next;
      data_out  <= data_next;
      valid     <= valid_next;
      frame_err <= frame_err_next;
    end
  end

  // The start bit is judged at its midpoint; every later bit one full period after the previous one.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    index_next     = index;
    shifter_next   = shifter;
    data_next      = data_out;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        cnt_next = cnt + 1'b1;
        if (cnt == HALF_LAST) begin
          cnt_next   = '0;
          index_next = '0;
          state_next = bit_val ? IDLE : DATA;
        end
      end
      DATA: begin
        cnt_next = cnt + 1'b1;
        if (cnt == FULL_LAST) begin
          cnt_next              = '0;
          shifter_next[index]   = bit_val;
          if (index == 3'd7) begin
            state_next = STOP;
          end else begin
            index_next = index + 1'b1;
          end
        end
      end
      STOP: begin
        cnt_next = cnt + 1'b1;
        if (cnt == FULL_LAST) begin
          cnt_next = '0;
          if (bit_val) begin
            data_next  = shifter;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven, hand-written and randomized frames against a frame-level model of uart_rx.
// Expected glitch result depends on whether UART_RX_MAJORITY_EN is defined for the build.
module tb_uart_rx;

  localparam int C     = 16;
  localparam int FRAME = 10 * C;
  localparam int EVAL  = 2 + C / 2 + 9 * C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLK_PER_BIT(C)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx       (rx),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         valid_cyc[$];
  logic [7:0] valid_data[$];
  int         err_cyc[$];
  int         both_pulses = 0;

  // Pulse log: cyc here is the index of the edge that raised the pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_cyc.push_back(cyc);
        valid_data.push_back(data_out);
      end
      if (frame_err) err_cyc.push_back(cyc);
      if (valid && frame_err) both_pulses++;
    end
  end

  int passed = 0;
  int total  = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  task automatic clear_log();
    valid_cyc.delete();
    valid_data.delete();
    err_cyc.delete();
  endtask

  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  // Drives ncyc cycles of a frame from a negedge; e0 is the first edge that samples the start bit.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop, input int glitch_at,
                                input int ncyc, output int e0);
    logic [9:0] frame;
    frame = {stop, data, 1'b0};
    e0 = cyc + 1;
    for (int k = 0; k < ncyc; k++) begin
      rx = frame[k / C];
      if (k == glitch_at) rx = ~rx;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         low_hold;
    int         gap;
    logic       exp_valid;
    logic       exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[7];
  int         valid_abs[7];
  int         e0;
  logic [7:0] exp_bytes[$];
  int         exp_e0[$];
  logic [7:0] rnd_byte;
  int         rnd_gap;
  int         glitch_exp;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 0,  0, 1'b1, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 0,  0, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 0,  4, 1'b1, 1'b0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 40, 4, 1'b0, 1'b1, 8'hFF};
    vecs[4] = '{8'h55, 1'b1, 0,  4, 1'b1, 1'b0, 8'h55};
    vecs[5] = '{8'h81, 1'b0, 0,  4, 1'b0, 1'b1, 8'h55};
    vecs[6] = '{8'hC3, 1'b1, 0,  2, 1'b1, 1'b0, 8'hC3};

    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_data_out", data_out, 0);
    check_output("reset_valid", valid, 0);
    check_output("reset_frame_err", frame_err, 0);
    check_output("reset_busy", busy, 0);
    rst_n = 1'b1;
    hold_rx(1'b1, 4);

    for (int i = 0; i < 7; i++) begin
      clear_log();
      valid_abs[i] = -1;
      apply_stimulus(vecs[i].data, vecs[i].stop, -1, FRAME, e0);
      hold_rx(1'b0, vecs[i].low_hold);
      check_output($sformatf("vec%0d_busy_held", i), busy, vecs[i].exp_err);
      hold_rx(1'b1, vecs[i].gap);
      check_output($sformatf("vec%0d_valid_count", i), valid_cyc.size(), vecs[i].exp_valid);
      check_output($sformatf("vec%0d_err_count", i), err_cyc.size(), vecs[i].exp_err);
      check_output($sformatf("vec%0d_data_out", i), data_out, vecs[i].exp_data);
      check_output($sformatf("vec%0d_busy_after", i), busy, 0);
      if (vecs[i].exp_valid) begin
        check_output($sformatf("vec%0d_valid_time", i),
                     (valid_cyc.size() > 0) ? valid_cyc[0] - e0 : -1, EVAL);
        if (valid_cyc.size() > 0) valid_abs[i] = valid_cyc[0];
      end
      if (vecs[i].exp_err) begin
        check_output($sformatf("vec%0d_err_time", i),
                     (err_cyc.size() > 0) ? err_cyc[0] - e0 : -1, EVAL);
      end
    end
    check_output("b2b_spacing", valid_abs[2] - valid_abs[1], FRAME);

    // False start: 3 low cycles, rejected at the start-bit midpoint.
    clear_log();
    e0 = cyc + 1;
    hold_rx(1'b0, 3);
    hold_rx(1'b1, 7);
    check_output("false_start_busy_before", busy, 1);
    hold_rx(1'b1, 1);
    check_output("false_start_busy_after", busy, 0);
    hold_rx(1'b1, 20);
    check_output("false_start_valid_count", valid_cyc.size(), 0);
    check_output("false_start_err_count", err_cyc.size(), 0);

    // Glitch on the evaluation edge of data bit 3.
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h00;
`else
    glitch_exp = 8'h08;
`endif
    clear_log();
    apply_stimulus(8'h00, 1'b1, 2 + C / 2 + 4 * C - 2, FRAME, e0);
    hold_rx(1'b1, 4);
    check_output("glitch_valid_count", valid_cyc.size(), 1);
    check_output("glitch_data_out", data_out, glitch_exp);

    // Reset during data bit 4 of 0x81.
    clear_log();
    apply_stimulus(8'h81, 1'b1, -1, 5 * C + 8, e0);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    check_output("midreset_data_out", data_out, 0);
    check_output("midreset_valid", valid, 0);
    check_output("midreset_frame_err", frame_err, 0);
    check_output("midreset_busy", busy, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    hold_rx(1'b1, 2 * C);
    check_output("midreset_no_valid", valid_cyc.size(), 0);
    check_output("midreset_no_err", err_cyc.size(), 0);
    apply_stimulus(8'h81, 1'b1, -1, FRAME, e0);
    hold_rx(1'b1, 4);
    check_output("post_reset_valid_count", valid_cyc.size(), 1);
    check_output("post_reset_data_out", data_out, 8'h81);

    // Random good frames with random idle gaps.
    clear_log();
    for (int n = 0; n < 20; n++) begin
      rnd_byte = 8'($urandom_range(0, 255));
      rnd_gap  = $urandom_range(0, 6);
      apply_stimulus(rnd_byte, 1'b1, -1, FRAME, e0);
      exp_bytes.push_back(rnd_byte);
      exp_e0.push_back(e0);
      hold_rx(1'b1, rnd_gap);
    end
    hold_rx(1'b1, 4);
    check_output("rand_valid_count", valid_cyc.size(), exp_bytes.size());
    check_output("rand_err_count", err_cyc.size(), 0);
    for (int i = 0; i < exp_bytes.size(); i++) begin
      check_output($sformatf("rand%0d_data", i),
                   (i < valid_data.size()) ? int'(valid_data[i]) : -1, exp_bytes[i]);
      check_output($sformatf("rand%0d_time", i),
                   (i < valid_cyc.size()) ? valid_cyc[i] : -1, exp_e0[i] + EVAL);
    end

    check_output("no_simultaneous_pulses", both_pulses, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
